// File: rtl/ir_rx_pkg.sv
// Shared types for the pulse-width IR frame receiver.
// FSM state encoding, error cause codes and the width window test.
package ir_rx_pkg;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_LEAD_LO = 6'b000010,
    S_LEAD_HI = 6'b000100,
    S_DATA    = 6'b001000,
    S_STOP    = 6'b010000,
    S_GAP     = 6'b100000
  } ir_state_e;

  localparam logic [1:0] ERR_LEAD = 2'd0;
  localparam logic [1:0] ERR_BIT  = 2'd1;
  localparam logic [1:0] ERR_STOP = 2'd2;
  localparam logic [1:0] ERR_CPL  = 2'd3;

  localparam int         GAP_HI = 16;
  localparam logic [7:0] W_SAT  = 8'hFF;

  function automatic logic in_window(
    input logic [7:0] width,
    input int         nominal,
    input int         tol
  );
    int w;
    w = int'(width);
    return (w >= nominal - tol) && (w <= nominal + tol);
  endfunction

endpackage

// File: rtl/ir_rx_frontend.sv
// IR input conditioning: tick prescaler, synchroniser, glitch filter.
// Ports: sys_clk/sys_rst in, remote_in in; tick/level/rise/fall/width out.
module ir_rx_frontend #(
  parameter int CLK_DIV = 6250,
  parameter int FILT    = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       remote_in,
  output logic       tick,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic [7:0] width
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(FILT + 1);

  logic [PW-1:0] pre;
  logic          pre_wrap;
  logic [1:0]    sync;
  logic [FW-1:0] run;
  logic [7:0]    wcnt;
  logic [7:0]    w_inc;
  logic          flip;

  assign pre_wrap = (pre == PW'(CLK_DIV - 1));
  assign w_inc    = (wcnt == 8'hFF) ? 8'hFF : wcnt + 8'd1;
  // level follows the sample only once FILT differing samples in a row
  assign flip     = (sync[1] != level) && ((int'(run) + 1) >= FILT);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pre   <= '0;
      sync  <= 2'b11;
      run   <= '0;
      level <= 1'b1;
      wcnt  <= 8'd0;
      tick  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      width <= 8'd0;
    end else begin
      sync <= {sync[0], remote_in};
      tick <= pre_wrap;
      rise <= 1'b0;
      fall <= 1'b0;
      if (pre_wrap) begin
        pre   <= '0;
        // width counts the current tick, so at an edge it is
        // the full length of the segment that just ended
        width <= w_inc;
        if (flip) begin
          level <= sync[1];
          rise  <= sync[1];
          fall  <= ~sync[1];
          run   <= '0;
          wcnt  <= 8'd0;
        end else begin
          wcnt <= w_inc;
          run  <= (sync[1] != level) ? run + 1'b1 : '0;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_receive_gen2.sv
// Pulse-width IR frame receiver: lead / N data bits / stop decoding.
// Ports: sys_clk, sys_rst, remote_in in; data_valid, data, repeat_flag, frame_err, err_code, busy out.
module ir_receive_gen2
  import ir_rx_pkg::*;
#(
  parameter int CLK_DIV    = 6250,
  parameter int DATA_W     = 16,
  parameter int LEAD_LO    = 24,
  parameter int LEAD_HI    = 24,
  parameter int BIT0_HI    = 12,
  parameter int BIT1_HI    = 20,
  parameter int STOP_HI    = 28,
  parameter int TOL        = 2,
  parameter int LOW_MAX    = 16,
  parameter int CHECK_CPL  = 1,
  parameter int REPEAT_WIN = 1600,
  parameter int FILT       = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                remote_in,
  output logic                data_valid,
  output logic [DATA_W/2-1:0] data,
  output logic                repeat_flag,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int HW = DATA_W / 2;
  localparam int BW = $clog2(DATA_W + 1);

  logic        tick;
  logic        level;
  logic        rise;
  logic        fall;
  logic [7:0]  width;

  ir_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] prev;
  logic              prev_ok;
  logic [BW-1:0]     bcnt;
  logic [15:0]       rcnt;
  logic              sat;
  logic              cpl_ok;
  logic              err_hit;
  logic [1:0]        err_sel;

  ir_rx_frontend #(
    .CLK_DIV (CLK_DIV),
    .FILT    (FILT)
  ) u_fe (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .remote_in (remote_in),
    .tick      (tick),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .width     (width)
  );

  assign sat    = (width == W_SAT);
  assign cpl_ok = (CHECK_CPL == 0) ||
                  (shreg[DATA_W-1:HW] == ~shreg[HW-1:0]);
  assign busy   = (state != S_IDLE);

  always_comb begin
    err_hit = 1'b0;
    err_sel = ERR_LEAD;
    if (tick) begin
      unique case (1'b1)
        state == S_LEAD_LO:
          err_hit = sat ||
            (rise && !in_window(width, LEAD_LO, TOL));
        state == S_LEAD_HI:
          err_hit = sat ||
            (fall && !in_window(width, LEAD_HI, TOL));
        state == S_DATA: begin
          err_sel = ERR_BIT;
          err_hit = sat ||
            (rise && (width > 8'(LOW_MAX))) ||
            (fall && !in_window(width, BIT0_HI, TOL) &&
                     !in_window(width, BIT1_HI, TOL));
        end
        state == S_STOP: begin
          err_sel = ERR_STOP;
          if (sat || (fall && !in_window(width, STOP_HI, TOL))) begin
            err_hit = 1'b1;
          end else if (fall && !cpl_ok) begin
            err_hit = 1'b1;
            err_sel = ERR_CPL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      prev        <= '0;
      prev_ok     <= 1'b0;
      bcnt        <= '0;
      rcnt        <= 16'd0;
      data_valid  <= 1'b0;
      data        <= '0;
      repeat_flag <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        if (rcnt != 16'hFFFF) rcnt <= rcnt + 16'd1;
        if (err_hit) begin
          frame_err <= 1'b1;
          err_code  <= err_sel;
          state     <= S_GAP;
        end else begin
          unique case (state)
            S_IDLE:
              if (fall) state <= S_LEAD_LO;
            S_LEAD_LO:
              if (rise) state <= S_LEAD_HI;
            S_LEAD_HI:
              if (fall) begin
                state <= S_DATA;
                bcnt  <= '0;
              end
            S_DATA:
              if (fall) begin
                shreg <= {shreg[DATA_W-2:0],
                          in_window(width, BIT1_HI, TOL)};
                bcnt  <= bcnt + 1'b1;
              end else if (rise && bcnt == BW'(DATA_W)) begin
                state <= S_STOP;
              end
            S_STOP:
              if (fall) begin
                state       <= S_GAP;
                data_valid  <= 1'b1;
                data        <= shreg[HW-1:0];
                repeat_flag <= prev_ok && (shreg == prev) &&
                               (rcnt < 16'(REPEAT_WIN));
                prev        <= shreg;
                prev_ok     <= 1'b1;
                // 1 = this tick, so rcnt reads ticks since accept
                rcnt        <= 16'd1;
              end
            S_GAP:
              if (level && width >= 8'(GAP_HI)) state <= S_IDLE;
            default:
              state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_receive_gen2.sv
// Self-checking bench for ir_receive_gen2 (complement check on and off).
// Segment-level frame model predicts strobes, data, repeat and cause.
`timescale 1ns/1ps
module tb_ir_receive_gen2;

  localparam int CLK_DIV    = 4;
  localparam int DATA_W     = 16;
  localparam int LEAD_LO    = 24;
  localparam int LEAD_HI    = 24;
  localparam int BIT0_HI    = 12;
  localparam int BIT1_HI    = 20;
  localparam int STOP_HI    = 28;
  localparam int TOL        = 2;
  localparam int LOW_MAX    = 16;
  localparam int REPEAT_WIN = 1600;
  localparam int FILT       = 2;

  typedef struct {
    int          kind;
    int          code;
    logic [15:0] pay;
  } res_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       remote_in = 1'b1;
  logic [1:0] dv;
  logic [1:0] rp;
  logic [1:0] fe;
  logic [1:0] bz;
  logic [7:0] dat [2];
  logic [1:0] ec  [2];

  int          n_checks = 0;
  int          n_errors = 0;
  int          dv_cnt [2] = '{0, 0};
  int          fe_cnt [2] = '{0, 0};
  int          both_cnt = 0;
  logic [7:0]  cap_data [2];
  logic        cap_rpt  [2];
  logic [1:0]  cap_ec   [2];
  logic [15:0] prev [2];
  bit          prev_ok [2] = '{0, 0};
  int          last_t [2] = '{0, 0};
  int          now = 0;
  int          fr [$];

  ir_receive_gen2 #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .LEAD_LO(LEAD_LO),
    .LEAD_HI(LEAD_HI), .BIT0_HI(BIT0_HI), .BIT1_HI(BIT1_HI),
    .STOP_HI(STOP_HI), .TOL(TOL), .LOW_MAX(LOW_MAX),
    .CHECK_CPL(1), .REPEAT_WIN(REPEAT_WIN), .FILT(FILT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .remote_in(remote_in),
    .data_valid(dv[0]), .data(dat[0]), .repeat_flag(rp[0]),
    .frame_err(fe[0]), .err_code(ec[0]), .busy(bz[0])
  );

  ir_receive_gen2 #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .LEAD_LO(LEAD_LO),
    .LEAD_HI(LEAD_HI), .BIT0_HI(BIT0_HI), .BIT1_HI(BIT1_HI),
    .STOP_HI(STOP_HI), .TOL(TOL), .LOW_MAX(LOW_MAX),
    .CHECK_CPL(0), .REPEAT_WIN(REPEAT_WIN), .FILT(FILT)
  ) dut_nc (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .remote_in(remote_in),
    .data_valid(dv[1]), .data(dat[1]), .repeat_flag(rp[1]),
    .frame_err(fe[1]), .err_code(ec[1]), .busy(bz[1])
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dv[k]) begin
        dv_cnt[k]++;
        cap_data[k] = dat[k];
        cap_rpt[k]  = rp[k];
      end
      if (fe[k]) begin
        fe_cnt[k]++;
        cap_ec[k] = ec[k];
      end
      if (dv[k] && fe[k]) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit inw(input int w, input int nom);
    return (w - nom <= TOL) && (nom - w <= TOL);
  endfunction

  function automatic int jv(input int nom, input bit jit);
    return jit ? nom + int'($urandom_range(0, 2 * TOL)) - TOL : nom;
  endfunction

  function automatic int sum_to(input int q[$], input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += q[i];
    return s;
  endfunction

  // segments alternate low/high starting with the lead low;
  // kind 0 = no frame, 1 = accepted, 2 = rejected with code
  function automatic res_t model(input int w[$], input bit cpl);
    res_t r;
    int   lo;
    int   hi;
    r.kind = 0;
    r.code = 0;
    r.pay  = 16'h0;
    if (w.size() == 0) return r;
    r.kind = 2;
    if (!inw(w[0], LEAD_LO)) return r;
    if (!inw(w[1], LEAD_HI)) return r;
    r.code = 1;
    for (int b = 0; b < DATA_W; b++) begin
      lo = w[2 + 2 * b];
      hi = w[3 + 2 * b];
      if (lo > LOW_MAX) return r;
      if (inw(hi, BIT1_HI))      r.pay = {r.pay[14:0], 1'b1};
      else if (inw(hi, BIT0_HI)) r.pay = {r.pay[14:0], 1'b0};
      else return r;
    end
    if (w[2 + 2 * DATA_W] > LOW_MAX) return r;
    r.code = 2;
    if (!inw(w[3 + 2 * DATA_W], STOP_HI)) return r;
    r.code = 3;
    if (cpl && (r.pay[15:8] != ~r.pay[7:0])) return r;
    r.kind = 1;
    return r;
  endfunction

  task automatic idle(input int n);
    remote_in = 1'b1;
    repeat (n * CLK_DIV) @(negedge sys_clk);
    now += n;
  endtask

  task automatic send(input int q[$]);
    foreach (q[i]) begin
      remote_in = (i % 2 == 1);
      repeat (q[i] * CLK_DIV) @(negedge sys_clk);
      now += q[i];
    end
    idle(30);
  endtask

  task automatic build(input logic [15:0] pay, input bit jit,
                       input int lead, input int bad_bit,
                       input int bad_hi, input int stop);
    fr.delete();
    fr.push_back(lead);
    fr.push_back(jv(LEAD_HI, jit));
    for (int b = 0; b < DATA_W; b++) begin
      fr.push_back(jit ? int'($urandom_range(3, 8)) : 4);
      if (b == bad_bit) begin
        fr.push_back(bad_hi);
        fr.push_back(4);
        return;
      end
      fr.push_back(jv(pay[DATA_W-1-b] ? BIT1_HI : BIT0_HI, jit));
    end
    fr.push_back(jit ? int'($urandom_range(3, 8)) : 4);
    fr.push_back(stop);
    fr.push_back(4);
  endtask

  task automatic run_frame(input string tag, input int raw[$],
                           input int seg[$]);
    int   dv0 [2];
    int   fe0 [2];
    int   t0;
    int   tacc;
    bit   er;
    res_t r;
    for (int k = 0; k < 2; k++) begin
      dv0[k] = dv_cnt[k];
      fe0[k] = fe_cnt[k];
    end
    t0 = now;
    send(raw);
    for (int k = 0; k < 2; k++) begin
      r = model(seg, k == 0);
      chk($sformatf("%s/u%0d/valid", tag, k), dv_cnt[k] - dv0[k],
          (r.kind == 1) ? 1 : 0);
      chk($sformatf("%s/u%0d/err", tag, k), fe_cnt[k] - fe0[k],
          (r.kind == 2) ? 1 : 0);
      if (r.kind == 1) begin
        tacc = t0 + sum_to(seg, 2 * DATA_W + 4);
        er = prev_ok[k] && (prev[k] == r.pay) &&
             (tacc - last_t[k] < REPEAT_WIN);
        chk($sformatf("%s/u%0d/data", tag, k), cap_data[k], r.pay[7:0]);
        chk($sformatf("%s/u%0d/rpt", tag, k), cap_rpt[k], er);
        prev[k]    = r.pay;
        prev_ok[k] = 1'b1;
        last_t[k]  = tacc;
      end
      if (r.kind == 2)
        chk($sformatf("%s/u%0d/code", tag, k), cap_ec[k], r.code);
      chk($sformatf("%s/u%0d/busy", tag, k), bz[k], 0);
    end
  endtask

  function automatic logic [15:0] rnd_pay();
    logic [7:0] lo;
    lo = 8'($urandom_range(0, 255));
    return {~lo, lo};
  endfunction

  initial begin
    int raw [$];
    int nil [$];
    int d0;
    int f0;

    repeat (5) @(negedge sys_clk);
    chk("rst/valid", dv[0], 0);
    chk("rst/err", fe[0], 0);
    chk("rst/data", dat[0], 0);
    chk("rst/rpt", rp[0], 0);
    chk("rst/code", ec[0], 0);
    chk("rst/busy", bz[0], 0);
    sys_rst = 1'b0;
    idle(30);

    build(16'h35CA, 0, LEAD_LO, -1, 0, STOP_HI);
    run_frame("a1", fr, fr);
    idle(400);
    run_frame("a2_rep", fr, fr);
    idle(1700);
    run_frame("a3_late", fr, fr);

    build(16'h34CA, 0, LEAD_LO, -1, 0, STOP_HI);
    run_frame("cpl", fr, fr);

    fr.delete();
    fr.push_back(19);
    run_frame("lead19", fr, fr);
    build(rnd_pay(), 0, LEAD_LO, -1, 0, STOP_HI);
    run_frame("ok_lead", fr, fr);

    build(16'h35CA, 0, LEAD_LO, 5, 16, STOP_HI);
    run_frame("bit16", fr, fr);
    build(rnd_pay(), 0, LEAD_LO, -1, 0, STOP_HI);
    run_frame("ok_bit", fr, fr);

    build(16'h35CA, 0, LEAD_LO, -1, 0, 35);
    run_frame("stop35", fr, fr);
    build(rnd_pay(), 0, LEAD_LO, -1, 0, STOP_HI);
    run_frame("ok_stop", fr, fr);

    raw.delete();
    raw.push_back(1);
    run_frame("glitch_idle", raw, nil);
    build(rnd_pay(), 0, LEAD_LO, -1, 0, STOP_HI);
    raw = fr;
    raw.delete(0);
    raw.push_front(12);
    raw.push_front(1);
    raw.push_front(11);
    run_frame("glitch_lead", raw, fr);

    build(rnd_pay(), 0, LEAD_LO, -1, 0, STOP_HI);
    d0 = dv_cnt[0] + dv_cnt[1];
    f0 = fe_cnt[0] + fe_cnt[1];
    for (int i = 0; i < 2 + 2 * 8; i++) begin
      remote_in = (i % 2 == 1);
      repeat (fr[i] * CLK_DIV) @(negedge sys_clk);
      now += fr[i];
    end
    chk("midrst/busy_before", bz[0], 1);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("midrst/valid", dv[0], 0);
    chk("midrst/err", fe[0], 0);
    chk("midrst/data", dat[0], 0);
    chk("midrst/rpt", rp[0], 0);
    chk("midrst/code", ec[0], 0);
    chk("midrst/busy", bz[0], 0);
    sys_rst = 1'b0;
    prev_ok[0] = 1'b0;
    prev_ok[1] = 1'b0;
    idle(30);
    chk("midrst/no_strobe", (dv_cnt[0] + dv_cnt[1] + fe_cnt[0] +
        fe_cnt[1]) - (d0 + f0), 0);
    build(rnd_pay(), 0, LEAD_LO, -1, 0, STOP_HI);
    run_frame("after_rst", fr, fr);

    for (int i = 0; i < 4; i++) begin
      build(rnd_pay(), 1, jv(LEAD_LO, 1), -1, 0, jv(STOP_HI, 1));
      run_frame($sformatf("rnd%0d", i), fr, fr);
    end

    chk("no_coincide", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ir_receive_gen2.md
Name: ir_receive_gen2

Overview:
- Parametrised second-generation pulse-width IR frame receiver for the OSD remote-control path.
- Runs entirely on sys_clk with an internal tick enable; there is no derived clock.
- Decodes a lead-low / lead-high / N-bit / stop frame and optionally checks that the frame's high and low halves are complements.
- Reports decoded data with a one-cycle valid strobe, an auto-repeat flag, and an error strobe with cause code.

Parameters:
- CLK_DIV, 6250: sys_clk cycles per sampling tick (50 MHz -> 8 kHz, 0.125 ms).
- DATA_W, 16: payload bits per frame; must be even, 2..32.
- LEAD_LO, 24: nominal lead low width, in ticks.
- LEAD_HI, 24: nominal lead high width, in ticks.
- BIT0_HI, 12: nominal high width of a logic 0, in ticks.
- BIT1_HI, 20: nominal high width of a logic 1, in ticks.
- STOP_HI, 28: nominal stop high width, in ticks.
- TOL, 2: accepted deviation, ± ticks, applied to every nominal width.
- LOW_MAX, 16: maximum inter-bit low width, in ticks.
- CHECK_CPL, 1: 1 requires upper DATA_W/2 bits == ~lower DATA_W/2 bits.
- REPEAT_WIN, 1600: window in ticks (200 ms) for repeat detection.
- FILT, 2: consecutive equal tick samples needed to accept an input level change.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- remote_in  in  1  raw IR demodulator output; idle high.
- data_valid  out  1  one-cycle strobe; frame accepted.
- data  out  DATA_W/2  lower half of the accepted payload.
- repeat  out  1  qualifies data_valid; frame identical to previous and inside REPEAT_WIN.
- frame_err  out  1  one-cycle strobe; frame rejected.
- err_code  out  2  cause: 0 lead, 1 bit/low timeout, 2 stop, 3 complement mismatch; held until the next frame_err.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs are 0, FSM enters IDLE, all counters clear, filtered level = 1, no previous frame is stored.
- Tick generation: a prescaler wraps at CLK_DIV-1 and produces a one-cycle tick.
- Input conditioning:
  - remote_in passes through a 2-flop sys_clk synchroniser.
  - The synchronised level is sampled on ticks.
  - The filtered level changes only after FILT consecutive differing tick samples.
  - Edges are defined on the filtered level.
- Width counter: 8-bit, counts ticks since the last filtered edge, saturates at 255, clears on every filtered edge.
- "In window" means nominal-TOL <= width <= nominal+TOL.
- FSM transitions (all evaluated on ticks):
  - IDLE -> LEAD_LO on a falling edge.
  - LEAD_LO -> LEAD_HI on a rising edge with width in window LEAD_LO; otherwise error 0.
  - LEAD_HI -> DATA on a falling edge with width in window LEAD_HI; otherwise error 0.
  - DATA:
    - A rising edge ends the low segment; low width > LOW_MAX gives error 1.
    - A falling edge ends the high segment. Width in window BIT0_HI shifts in 0; in window BIT1_HI shifts in 1; anything else is error 1.
    - Shifting is MSB first: shreg <= {shreg[DATA_W-2:0], bit}.
    - When the bit count reaches DATA_W and the line is high -> STOP.
  - STOP -> GAP on a falling edge with width in window STOP_HI. Otherwise error 2.
  - On that falling edge, if CHECK_CPL and the complement test fails -> error 3; else accept.
  - GAP returns to IDLE after the line has been high for 16 ticks.
- Timeouts: in any non-IDLE, non-GAP state, a saturated width counter raises the error for that state (0 lead, 1 data, 2 stop).
- Any error: frame_err pulses, err_code updates, FSM goes to GAP, and data/repeat remain unchanged.
- Accept:
  - data <= shreg[DATA_W/2-1:0].
  - data_valid pulses for one sys_clk, registered in the cycle after the detecting tick.
  - repeat = 1 if shreg equals the stored previous frame and the ticks since the previous accept are < REPEAT_WIN (16-bit saturating counter).
  - Store shreg as the previous frame and restart the repeat counter.
- Simultaneous error and accept cannot occur (the conditions are exclusive). A frame_err strobe and a data_valid strobe never coincide.
- A falling edge arriving during GAP is ignored. The lead is re-detected only from IDLE.
- Asserting sys_rst mid-frame aborts with no strobe. A frame already in progress at release is not decoded until the line has been high long enough for IDLE.

Decomposition:
- Package ir_rx_pkg:
  - FSM state enum (IDLE, LEAD_LO, LEAD_HI, DATA, STOP, GAP), one-hot.
  - err_code constants.
  - An in_window(width, nominal, tol) function.
- Sub-module ir_rx_frontend: tick prescaler, synchroniser, FILT glitch filter, edge strobes, width counter. Outputs tick, level, rise, fall, width.

Test Plan:
- CLK_DIV=4. Send lead 24/24, payload 0x35CA (bit highs 12/20, lows 4), stop 28 -> data_valid=1 for one cycle, data=0xCA, repeat=0, frame_err=0.
- Same frame resent 400 ticks later -> data_valid, data=0xCA, repeat=1. Resent after 1700 ticks idle -> repeat=0.
- Payload 0x34CA (complement broken), CHECK_CPL=1 -> frame_err, err_code=3, no data_valid. With CHECK_CPL=0 -> data_valid, data=0xCA.
- Lead low 19 ticks -> frame_err, err_code=0. Bit high 16 ticks -> err_code=1. Stop high 35 -> err_code=2. Each case is followed by a good frame that decodes correctly.
- A 1-tick low glitch in idle and a 1-tick high glitch inside the lead low (FILT=2) -> no strobes; the lead is still accepted and the frame decodes.
- sys_rst pulsed after 8 payload bits -> all outputs 0, busy=0, no strobe; the next complete frame decodes.
